// File: rtl/iterative_alu.sv
// Execute-stage ALU: single-cycle ops with registered outputs, plus iterative
// multiply/divide into hi/lo (radix-2 shift-add, restoring division).
module iterative_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             start,
  input  logic [4:0]       operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] OP_ADD   = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_NOR  = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8,  OP_SLTU = 5'd9,  OP_SLL  = 5'd10, OP_SRL  = 5'd11;
  localparam logic [4:0] OP_SRA   = 5'd12, OP_MUL  = 5'd13, OP_MFHI = 5'd14, OP_MFLO = 5'd15;
  localparam logic [4:0] OP_MULT  = 5'd16, OP_MULTU = 5'd17, OP_DIV = 5'd18, OP_DIVU = 5'd19;

  localparam logic [SHW-1:0]   LAST    = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t               state;
  logic [SHW-1:0]       count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic                 neg_lo, neg_hi, is_div_r, ovf_r, dbz_r;

  // Operation decode and operand magnitudes for signed multi-cycle ops.
  logic             is_multi, is_div_op, is_signed_op, div_zero;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    is_multi     = operation inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    is_div_op    = operation inside {OP_DIV, OP_DIVU};
    is_signed_op = operation inside {OP_MULT, OP_DIV};
    div_zero     = is_div_op && (B == '0);
    sign_a       = is_signed_op & A[WIDTH-1];
    sign_b       = is_signed_op & B[WIDTH-1];
    mag_a        = sign_a ? -A : A;
    mag_b        = sign_b ? -B : B;
  end

  // Single-cycle result path.
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = A + B;
    diff    = A - B;
    case (operation)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: alu_res = WIDTH'(A < B);
      OP_SLL:  alu_res = B << shamt;
      OP_SRL:  alu_res = B >> shamt;
      OP_SRA:  alu_res = $signed(B) >>> shamt;
      OP_MUL:  alu_res = A * B;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // One iteration step for each algorithm, and the final sign correction.
  logic [WIDTH:0]       add_sum, shl_rem, trial;
  logic [2*WIDTH-1:0]   mult_next, div_next, prod_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo, quot, rem;

  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    mult_next = {add_sum, acc[WIDTH-1:1]};
    shl_rem   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial     = shl_rem - {1'b0, opnd};
    div_next  = trial[WIDTH] ? {shl_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                             : {trial[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
    prod_fix  = neg_lo ? -acc : acc;
    quot      = acc[WIDTH-1:0];
    rem       = acc[2*WIDTH-1:WIDTH];
    fix_hi    = is_div_r ? (neg_hi ? -rem : rem)   : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo    = is_div_r ? (neg_lo ? -quot : quot) : prod_fix[WIDTH-1:0];
  end

  // Control FSM and architectural outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      result      <= '0;
      hi          <= '0;
      lo          <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (!stall) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_multi) begin
              busy  <= 1'b1;
              state <= div_zero ? S_FIX : S_ITER;
            end else begin
              result      <= alu_res;
              overflow    <= alu_ovf;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        S_ITER: if (count == LAST) state <= S_FIX;
        S_FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          result      <= fix_lo;
          overflow    <= ovf_r;
          div_by_zero <= dbz_r;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on acceptance
  // before being read, and reset returns the FSM to IDLE which abandons them.
  always_ff @(posedge clock) begin
    if (!stall) begin
      case (state)
        S_IDLE: begin
          if (start && is_multi) begin
            count    <= '0;
            is_div_r <= is_div_op;
            dbz_r    <= div_zero;
            ovf_r    <= (operation == OP_DIV) && (A == MIN_NEG) && (B == '1);
            if (div_zero) begin
              acc    <= {A, {WIDTH{1'b1}}};
              opnd   <= '0;
              neg_lo <= 1'b0;
              neg_hi <= 1'b0;
            end else if (is_div_op) begin
              acc    <= {{WIDTH{1'b0}}, mag_a};
              opnd   <= mag_b;
              neg_lo <= sign_a ^ sign_b;
              neg_hi <= sign_a;
            end else begin
              acc    <= {{WIDTH{1'b0}}, mag_b};
              opnd   <= mag_a;
              neg_lo <= sign_a ^ sign_b;
              neg_hi <= sign_a ^ sign_b;
            end
          end
        end
        S_ITER: begin
          count <= count + 1'b1;
          acc   <= is_div_r ? div_next : mult_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: the driver pushes reference-model
// expectations, an independent monitor pops and compares on every completion.
module tb_iterative_alu;

  localparam int W  = 32;
  localparam int SW = 5;

  localparam logic [4:0] OP_ADD   = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_NOR  = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8,  OP_SLTU = 5'd9,  OP_SLL  = 5'd10, OP_SRL  = 5'd11;
  localparam logic [4:0] OP_SRA   = 5'd12, OP_MUL  = 5'd13, OP_MFHI = 5'd14, OP_MFLO = 5'd15;
  localparam logic [4:0] OP_MULT  = 5'd16, OP_MULTU = 5'd17, OP_DIV = 5'd18, OP_DIVU = 5'd19;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic          clock = 1'b0;
  logic          reset = 1'b0, stall = 1'b0, start = 1'b0;
  logic [4:0]    operation = '0;
  logic [W-1:0]  A = '0, B = '0;
  logic [SW-1:0] shamt = '0;
  logic [W-1:0]  result, hi, lo;
  logic          overflow, div_by_zero, busy, done;

  always #5 clock = ~clock;

  iterative_alu #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .stall(stall), .start(start),
    .operation(operation), .A(A), .B(B), .shamt(shamt),
    .result(result), .overflow(overflow), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           edge_no;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: sequential ISA semantics, plain 64-bit arithmetic.
  // lat = clock edges from acceptance to the edge that raises done.
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [SW-1:0] sh, output exp_t e, output int lat);
    longint          sa, sb, t;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e = '{res: '0, ovf: 1'b0, dbz: 1'b0, hi: '0, lo: '0, edge_no: 0};
    lat = 0;
    case (op)
      OP_ADD:  begin t = sa + sb; e.res = t[31:0]; e.ovf = (t > MAXS) || (t < MINS); end
      OP_SUB:  begin t = sa - sb; e.res = t[31:0]; e.ovf = (t > MAXS) || (t < MINS); end
      OP_ADDU: e.res = a + b;
      OP_SUBU: e.res = a - b;
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_NOR:  e.res = ~(a | b);
      OP_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (ua < ub) ? 32'd1 : 32'd0;
      OP_SLL:  begin p = ub << sh; e.res = p[31:0]; end
      OP_SRL:  begin p = ub >> sh; e.res = p[31:0]; end
      OP_SRA:  begin t = sb >>> sh; e.res = t[31:0]; end
      OP_MUL:  begin t = sa * sb; e.res = t[31:0]; end
      OP_MFHI: e.res = m_hi;
      OP_MFLO: e.res = m_lo;
      OP_MULT:  begin t = sa * sb; {m_hi, m_lo} = t;  lat = W + 1; end
      OP_MULTU: begin p = ua * ub; {m_hi, m_lo} = p;  lat = W + 1; end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          m_hi = a; m_lo = '1; e.dbz = 1'b1; lat = 1;
        end else if (op == OP_DIV && sa == MINS && sb == -1) begin
          m_lo = a; m_hi = '0; e.ovf = 1'b1; lat = W + 1;
        end else if (op == OP_DIV) begin
          t = sa / sb; m_lo = t[31:0];
          t = sa % sb; m_hi = t[31:0];
          lat = W + 1;
        end else begin
          p = ua / ub; m_lo = p[31:0];
          p = ua % ub; m_hi = p[31:0];
          lat = W + 1;
        end
      end
      default: e.res = '0;
    endcase
    if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) e.res = m_lo;
    e.hi = m_hi;
    e.lo = m_lo;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Presents one op for exactly one edge; extra = stall cycles expected before done.
  task automatic drive_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SW-1:0] sh, input int extra, output int lat);
    exp_t e;
    model(op, a, b, sh, e, lat);
    e.edge_no = cyc + 1 + lat + extra;
    exp_q.push_back(e);
    operation = op; A = a; B = b; shamt = sh; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Issue and wait until the done cycle, so the next op issues back-to-back.
  task automatic run(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [SW-1:0] sh);
    int lat;
    drive_op(op, a, b, sh, 0, lat);
    idle(lat);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: a completion is a done seen after an edge where stall was low.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(posedge clock);
      s = stall;
      @(negedge clock);
      if (done === 1'b1 && s === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result",      result,      e.res);
          check("overflow",    overflow,    e.ovf);
          check("div_by_zero", div_by_zero, e.dbz);
          check("hi",          hi,          e.hi);
          check("lo",          lo,          e.lo);
          check("done_cycle",  cyc,         e.edge_no);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [4:0] op;

    idle(3);
    check("reset_result", result, 0);
    check("reset_hilo",   {hi, lo}, 0);
    check("reset_flags",  {overflow, div_by_zero, busy, done}, 0);
    reset = 1'b1;
    idle(1);

    // Directed corner cases.
    run(OP_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 0);
    run(OP_SUB,   32'h8000_0000, 32'h0000_0001, 0);
    run(OP_ADDU,  32'h7FFF_FFFF, 32'h0000_0001, 0);
    run(OP_SRA,   32'h0,         32'h8000_0000, 4);
    run(OP_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 0);
    run(OP_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 0);
    run(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 0);
    run(OP_MFHI,  32'h0, 32'h0, 0);
    run(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    run(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0);
    run(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 0);
    run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(OP_DIVU,  32'h0000_0100, 32'h0000_0007, 0);
    run(OP_MFLO,  32'h0, 32'h0, 0);
    run(5'd27,    32'h1234_5678, 32'h9ABC_DEF0, 3);

    // MULT with a dropped start at T+5 and a 4-cycle stall (start also held high) mid-ITER.
    drive_op(OP_MULT, 32'h1234_5678, 32'hF9AB_CDEF, 0, 4, lat);
    idle(4);
    operation = OP_DIV; A = 32'd99; B = 32'd3; start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(5);
    stall = 1'b1; start = 1'b1; operation = OP_ADD;
    idle(4);
    stall = 1'b0; start = 1'b0;
    idle(lat - 10);
    run(OP_MFHI, 32'h0, 32'h0, 0);

    // Reset during a DIV in flight: iteration abandoned, hi/lo cleared.
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    drive_op(OP_DIV, 32'd1000, 32'd3, 0, 0, lat);
    idle(5);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_hilo", {hi, lo}, 0);
    idle(W + 4);
    run(OP_MFHI, 32'h0, 32'h0, 0);
    run(OP_MFLO, 32'h0, 32'h0, 0);

    // Randomized mix, with occasional stalls (and ignored starts) between ops.
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 21));
      run(op, rnd_val(), rnd_val(), SW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 3);
        stall = 1'b1; start = 1'b1; operation = 5'($urandom_range(0, 19));
        idle(n);
        stall = 1'b0; start = 1'b0;
      end
    end

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) idle(1);
    check("queue_drain", exp_q.size(), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
